// File: rtl/imem_loader_if.sv
// Loader-side bundle: start pulse, byte stream handshake, instruction-memory write port and status.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 16
);
    logic                   start;
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   imem_we;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_wdata;
    logic                   cpu_hold;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [ADDR_WIDTH:0]    words_loaded;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_hold, busy, done, error, words_loaded
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_hold, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a length-prefixed byte stream into 16-bit words, writes them to instruction memory
// and releases the CPU only when the trailing XOR checksum matches.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_LEN, S_GET_HI, S_GET_LO, S_WRITE, S_GET_CSUM, S_DONE, S_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       words_q, words_d;
    logic [7:0]             hi_q, hi_d;
    logic [7:0]             csum_q, csum_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   ready_q, ready_d;
    logic                   hold_q, hold_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   byte_fire;
    logic [CNT_W-1:0]       words_inc;

    assign byte_fire = ready_q && bus.byte_valid;
    assign words_inc = words_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            words_q <= '0;
            hi_q    <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_GET_LEN;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    csum_d  = '0;
                    addr_d  = '0;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_GET_LEN: begin
                if (byte_fire) begin
                    // A zero length byte encodes a full memory image
                    len_d   = (bus.byte_in == 8'd0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                                    : CNT_W'(bus.byte_in);
                    csum_d  = csum_q ^ bus.byte_in;
                    state_d = S_GET_HI;
                end
            end
            S_GET_HI: begin
                if (byte_fire) begin
                    hi_d    = bus.byte_in;
                    csum_d  = csum_q ^ bus.byte_in;
                    state_d = S_GET_LO;
                end
            end
            S_GET_LO: begin
                if (byte_fire) begin
                    wdata_d = INSTR_WIDTH'({hi_q, bus.byte_in});
                    csum_d  = csum_q ^ bus.byte_in;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                words_d = words_inc;
                if (words_inc == len_q) begin
                    state_d = S_GET_CSUM;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_GET_HI;
                end
            end
            S_GET_CSUM: begin
                if (byte_fire) begin
                    busy_d = 1'b0;
                    if (bus.byte_in == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered, so derive them from the state being entered
        we_d    = (state_d == S_WRITE);
        ready_d = (state_d == S_GET_LEN) || (state_d == S_GET_HI) ||
                  (state_d == S_GET_LO)  || (state_d == S_GET_CSUM);
    end

    assign bus.byte_ready   = ready_q;
    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.cpu_hold     = hold_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = err_q;
    assign bus.words_loaded = words_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that fills the instruction memory read by the fetch unit, so it works on the opposite side of that memory from fetch. It accepts a byte stream over a valid/ready handshake, packs bytes into 16-bit instruction words and writes them to sequential instruction-memory addresses. It then checks a trailing XOR checksum. The CPU is held in reset (cpu_hold) until a load completes with a matching checksum.

Parameters:
ADDR_WIDTH, 8, instruction-memory address width; equals the program_counter width.
INSTR_WIDTH, 16, instruction word width; always two bytes.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader can accept a byte; a byte transfers when byte_valid && byte_ready
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_WIDTH  instruction-memory write address
imem_wdata  output  INSTR_WIDTH  instruction word to write
cpu_hold  output  1  holds the CPU (fetch/PC) in reset while high
busy  output  1  a load is in progress
done  output  1  last load completed with a matching checksum
error  output  1  last load failed its checksum
words_loaded  output  ADDR_WIDTH+1  number of words written in the current or last load

Behaviour:
- Reset (asynchronous, active-high). Values on reset:
  - state=IDLE
  - byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_hold=1, busy=0, done=0, error=0, words_loaded=0
  - internal length, hi-byte and checksum registers cleared
- States: IDLE, GET_LEN, GET_HI, GET_LO, WRITE, GET_CSUM, DONE, ERR.
- IDLE/DONE/ERR + start:
  - go to GET_LEN
  - clear done, error, words_loaded, checksum and word address
  - set cpu_hold=1, busy=1
- start in any other state is ignored.
- byte_ready=1 only in GET_LEN, GET_HI, GET_LO and GET_CSUM; 0 in all other states.
- A byte is consumed only in a cycle where byte_valid && byte_ready. byte_valid may drop between bytes; stalls are unbounded (no timeout).
- GET_LEN: consumed byte L sets word count N. L=1..255 gives N=L; L=0 gives N=256. Checksum ^= L. Next state GET_HI.
- GET_HI: capture hi byte, checksum ^= byte, next state GET_LO.
- GET_LO: capture lo byte, checksum ^= byte, next state WRITE.
- WRITE: lasts exactly one cycle.
  - imem_we=1, imem_addr=word index, imem_wdata={hi,lo} (big-endian)
  - words_loaded increments
  - if the incremented count == N, next state GET_CSUM; else word index +1 and next state GET_HI
- imem_we is 0 in every state except WRITE.
- Addresses run 0..N-1. With N=256 the last address is 0xFF; the index never wraps within a load.
- GET_CSUM: compare the consumed byte with the running XOR.
  - equal: DONE (done=1, busy=0, cpu_hold=0)
  - not equal: ERR (error=1, busy=0, cpu_hold stays 1)
- done and error are levels. They hold until the next accepted start or reset. They are never both 1.
- Latency: a word write occurs in the cycle after its lo byte is accepted. Minimum load time is 2N+2 accepted bytes plus N WRITE cycles.
- Reset mid-load: immediate return to the reset values. Words already written stay in memory. No further writes occur.
- A byte presented during WRITE, IDLE, DONE or ERR is not consumed. It stays on byte_in for the upstream to hold.

Test Plan:
- Nominal load:
  - start, then bytes 02,12,34,AB,CD,42
  - expect imem writes addr0=0x1234 and addr1=0xABCD, one cycle each
  - expect done=1, cpu_hold=0, words_loaded=2, error=0
- Bad checksum: same stream with last byte 43 -> both words written; error=1, done=0, cpu_hold=1.
- Backpressure and gaps:
  - nominal stream with byte_valid toggled 1-0-0-1 and a byte held during WRITE
  - expect no duplicate or missed bytes, byte_ready=0 during WRITE, identical result to the nominal load
- Full memory:
  - L=00, 256 words with word k = {k, ~k}, correct XOR
  - expect 256 writes, last at addr 0xFF, words_loaded=256, done=1
- Reset mid-load: assert rst after the first WRITE of a 4-word load -> all outputs at reset values immediately; a subsequent nominal load succeeds.
- Start while busy: pulse start during GET_LO -> ignored; the load completes normally; start after DONE clears done and restarts.
